mem_lsu: RTL

Load/store unit for the memory stage of the Vi RV64I pipeline. It consumes the effective address computed by the integer ALU for load (opcode 0000011) and store (opcode 0100011) instructions. It runs the data-memory request/grant/response handshake and returns size-aligned, sign- or zero-extended load data to writeback. The earlier pipeline stages stall while an access is in flight.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 45 ++++
 rtl/mem_lsu.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the memory-stage load/store unit: FSM states, opcodes,
// access sizes and byte-mask helpers.
package lsu_pkg;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t S_IDLE = 2'd0;
  localparam lsu_state_t S_REQ  = 2'd1;
  localparam lsu_state_t S_WAIT = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // funct3[1:0] gives the access size; funct3[2] selects zero-extension on loads
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [7:0] BE_B = 8'h01;
  localparam logic [7:0] BE_H = 8'h03;
  localparam logic [7:0] BE_W = 8'h0F;
  localparam logic [7:0] BE_D = 8'hFF;

  function automatic logic [7:0] be_base(input logic [1:0] size);
    case (size)
      SIZE_B:  be_base = BE_B;
      SIZE_H:  be_base = BE_H;
      SIZE_W:  be_base = BE_W;
      default: be_base = BE_D;
    endcase
  endfunction

  // Keeps only the byte-offset bits that a naturally aligned access of this size may use
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  align_mask = 3'b111;
      SIZE_H:  align_mask = 3'b110;
      SIZE_W:  align_mask = 3'b100;
      default: align_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store-data shifting for a new
// request, and extraction plus sign/zero extension of returned load data.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]        req_size,
  input  logic [2:0]        req_off,
  input  logic [DATA_W-1:0] store_data,
  output logic [7:0]        be,
  output logic [DATA_W-1:0] wdata,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [2:0]        ld_off,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] load_data
);

  logic [DATA_W-1:0] shifted;
  logic              ext;

  always_comb begin
    be      = be_base(req_size) << req_off;
    wdata   = store_data << {req_off, 3'b000};
    shifted = rdata >> {ld_off, 3'b000};
    ext     = 1'b0;
    case (ld_size)
      SIZE_B: begin
        ext       = ~ld_unsigned & shifted[7];
        load_data = {{(DATA_W-8){ext}}, shifted[7:0]};
      end
      SIZE_H: begin
        ext       = ~ld_unsigned & shifted[15];
        load_data = {{(DATA_W-16){ext}}, shifted[15:0]};
      end
      SIZE_W: begin
        ext       = ~ld_unsigned & shifted[31];
        load_data = {{(DATA_W-32){ext}}, shifted[31:0]};
      end
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: runs the dmem req/gnt/rvalid handshake and
// returns extended load data. Define LSU_MISALIGN_CHECK_EN to reject misaligned accesses.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              valid_i,
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic              stall_o,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [7:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i
);

  lsu_state_t state_q;
  logic [1:0] size_q;
  logic       unsigned_q;
  logic [2:0] off_q;
  logic [4:0] rd_q;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              is_load;
  logic              is_store;
  logic              accept;
  logic              misaligned;
  logic [2:0]        off_d;
  logic [7:0]        be_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] load_data;
  logic              unused_bits;

  assign unused_bits = ^instr_i[31:15];

  // Decode and acceptance; without the misalign check the offset is simply forced aligned
  always_comb begin
    opcode   = instr_i[6:0];
    funct3   = instr_i[14:12];
    is_load  = (opcode == OP_LOAD) && (funct3 != 3'b111);
    is_store = (opcode == OP_STORE) && !funct3[2];
    accept   = (state_q == S_IDLE) && valid_i && (is_load || is_store);
    off_d    = addr_i[2:0] & align_mask(funct3[1:0]);
`ifdef LSU_MISALIGN_CHECK_EN
    misaligned = (off_d != addr_i[2:0]);
`else
    misaligned = 1'b0;
`endif
  end

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .req_size    (funct3[1:0]),
    .req_off     (off_d),
    .store_data  (store_data_i),
    .be          (be_d),
    .wdata       (wdata_d),
    .ld_size     (size_q),
    .ld_unsigned (unsigned_q),
    .ld_off      (off_q),
    .rdata       (dmem_rdata_i),
    .load_data   (load_data)
  );

  always_ff @(posedge clk_i or posedge rsn_i) begin
    if (rsn_i) begin
      state_q      <= S_IDLE;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      off_q        <= '0;
      rd_q         <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      misalign_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              state_q      <= S_REQ;
              dmem_we_o    <= is_store;
              dmem_addr_o  <= {addr_i[DATA_W-1:3], 3'b000};
              dmem_be_o    <= be_d;
              dmem_wdata_o <= wdata_d;
              size_q       <= funct3[1:0];
              unsigned_q   <= funct3[2];
              off_q        <= off_d;
              rd_q         <= instr_i[11:7];
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt_i) state_q <= dmem_we_o ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          if (dmem_rvalid_i) begin
            wb_valid_o <= 1'b1;
            wb_data_o  <= load_data;
            wb_rd_o    <= rd_q;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Both follow the state register alone so an async reset clears them at once
  assign stall_o    = (state_q != S_IDLE);
  assign dmem_req_o = (state_q == S_REQ);

endmodule
